// File: rtl/wb_regfile.sv
// Write-back stage register plus 32-entry register file with two forwarding read ports.
// The WB entry commits into the array on the same edge that loads the next entry.
module wb_regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          regcWr,
    input  logic [AW-1:0] regcAddr,
    input  logic [DW-1:0] regcData,
    input  logic          stall,
    input  logic          flush,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    output logic          wb_wr,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data
);
    localparam int DEPTH = 2 ** AW;

    logic          r_wb_wr;
    logic [AW-1:0] r_wb_addr;
    logic [DW-1:0] r_wb_data;
    logic [DW-1:0] r_regs [DEPTH];

    logic          w_commit;

    assign w_commit = r_wb_wr && (r_wb_addr != '0);

    // flush only clears the valid bit; addr/data stay for visibility
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_wr   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (flush) begin
            r_wb_wr   <= 1'b0;
        end else if (!stall) begin
            r_wb_wr   <= regcWr;
            r_wb_addr <= regcAddr;
            r_wb_data <= regcData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[r_wb_addr] <= r_wb_data;
        end
    end

    // EX result is newer than the WB entry, so it is checked first
    always_comb begin
        rdata1 = '0;
        if (re1 && (raddr1 != '0)) begin
            if (regcWr && (regcAddr == raddr1)) begin
                rdata1 = regcData;
            end else if (r_wb_wr && (r_wb_addr == raddr1)) begin
                rdata1 = r_wb_data;
            end else begin
                rdata1 = r_regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (re2 && (raddr2 != '0)) begin
            if (regcWr && (regcAddr == raddr2)) begin
                rdata2 = regcData;
            end else if (r_wb_wr && (r_wb_addr == raddr2)) begin
                rdata2 = r_wb_data;
            end else begin
                rdata2 = r_regs[raddr2];
            end
        end
    end

    assign wb_wr   = r_wb_wr;
    assign wb_addr = r_wb_addr;
    assign wb_data = r_wb_data;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: reference model compared every negedge, plus directed literal checks.
module tb_wb_regfile;
    logic        clk;
    logic        rst;
    logic        regcWr;
    logic [4:0]  regcAddr;
    logic [31:0] regcData;
    logic        stall;
    logic        flush;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        wb_wr;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    bit [31:0] m_regs [32];
    bit        m_wb_wr;
    bit [4:0]  m_wb_addr;
    bit [31:0] m_wb_data;

    wb_regfile #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .regcWr(regcWr), .regcAddr(regcAddr), .regcData(regcData),
        .stall(stall), .flush(flush),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: pending entry commits with its old contents, then the stage reloads
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= '0;
            m_wb_wr   <= 1'b0;
            m_wb_addr <= '0;
            m_wb_data <= '0;
        end else begin
            if (m_wb_wr && m_wb_addr != 0) m_regs[m_wb_addr] <= m_wb_data;
            if (flush) begin
                m_wb_wr <= 1'b0;
            end else if (!stall) begin
                m_wb_wr   <= regcWr;
                m_wb_addr <= regcAddr;
                m_wb_data <= regcData;
            end
        end
    end

    function automatic bit [31:0] m_read(input bit re, input bit [4:0] a);
        if (!re || a == 0) return 32'h0;
        if (regcWr && regcAddr == a) return regcData;
        if (m_wb_wr && m_wb_addr == a) return m_wb_data;
        return m_regs[a];
    endfunction

    always @(negedge clk) begin
        chk("model wb_wr",   {31'b0, wb_wr}, {31'b0, m_wb_wr});
        chk("model wb_addr", {27'b0, wb_addr}, {27'b0, m_wb_addr});
        chk("model wb_data", wb_data, m_wb_data);
        chk("model rdata1",  rdata1, m_read(re1, raddr1));
        chk("model rdata2",  rdata2, m_read(re2, raddr2));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ex(input logic wr, input logic [4:0] a, input logic [31:0] d);
        regcWr = wr; regcAddr = a; regcData = d;
    endtask

    initial begin
        rst = 1'b1;
        ex(0, 0, 0);
        stall = 0; flush = 0;
        re1 = 1; raddr1 = 0; re2 = 1; raddr2 = 0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // basic write then read back from each stage
        ex(1, 3, 32'h12345678); raddr2 = 3; #1;
        chk("basic ex fwd", rdata2, 32'h12345678);
        tick();
        ex(0, 0, 0); #1;
        chk("basic wb_wr", {31'b0, wb_wr}, 32'h1);
        chk("basic wb fwd", rdata2, 32'h12345678);
        tick(); #1;
        chk("basic array", rdata2, 32'h12345678);
        chk("basic wb_wr idle", {31'b0, wb_wr}, 32'h0);
        tick();

        // EX hit beats WB hit on the same address
        ex(1, 7, 32'h1111); raddr1 = 7;
        tick();
        ex(1, 7, 32'h2222); #1;
        chk("prio ex wins", rdata1, 32'h2222);
        regcWr = 0; #1;
        chk("prio wb after drop", rdata1, 32'h1111);
        tick();

        // register 0 never written, never forwarded
        ex(1, 0, 32'hFFFFFFFF); raddr1 = 0; #1;
        chk("zero ex cycle", rdata1, 32'h0);
        tick();
        ex(0, 0, 0); #1;
        chk("zero wb_wr", {31'b0, wb_wr}, 32'h1);
        chk("zero wb_data", wb_data, 32'hFFFFFFFF);
        chk("zero wb cycle", rdata1, 32'h0);
        tick(); #1;
        chk("zero after", rdata1, 32'h0);

        // stall holds the entry while EX moves on
        ex(1, 9, 32'hAAAA);
        tick();
        stall = 1;
        ex(1, 10, 32'hBBBB); tick();
        ex(1, 11, 32'hCCCC); tick();
        ex(1, 12, 32'hDDDD); tick(); #1;
        chk("stall wb_addr", {27'b0, wb_addr}, 32'd9);
        chk("stall wb_data", wb_data, 32'hAAAA);
        chk("stall wb_wr", {31'b0, wb_wr}, 32'h1);
        flush = 1;
        ex(1, 13, 32'hEEEE); raddr1 = 13; raddr2 = 9; #1;
        chk("flush ex fwd", rdata1, 32'hEEEE);
        chk("flush wb fwd", rdata2, 32'hAAAA);
        tick();
        flush = 0; stall = 0;
        ex(0, 0, 0); #1;
        chk("flush wb_wr", {31'b0, wb_wr}, 32'h0);
        chk("flush wb_addr kept", {27'b0, wb_addr}, 32'd9);
        chk("flush no fwd", rdata1, 32'h0);
        chk("flush committed", rdata2, 32'hAAAA);
        tick();

        // read disable masks even an EX hit
        re2 = 0; raddr2 = 14; ex(1, 14, 32'h5555); #1;
        chk("re2 off", rdata2, 32'h0);
        re2 = 1; #1;
        chk("re2 on", rdata2, 32'h5555);
        tick();

        // async reset clears array and drops a pending entry
        ex(1, 5, 32'hDEAD); tick();
        ex(0, 0, 0); tick(); tick();
        raddr1 = 5; #1;
        chk("reset preload", rdata1, 32'hDEAD);
        ex(1, 6, 32'h66); tick();
        ex(0, 0, 0); #1;
        rst = 1; #1;
        chk("reset rdata1", rdata1, 32'h0);
        chk("reset wb_wr", {31'b0, wb_wr}, 32'h0);
        tick();
        rst = 0; raddr2 = 6;
        tick(); tick(); #1;
        chk("reset no commit", rdata2, 32'h0);
        chk("reset reg5", rdata1, 32'h0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the EX result interface (regcWr/regcAddr/regcData).
- Latches each EX result into a one-entry write-back stage register.
- Commits the latched result into a 32x32 general register file.
- Serves two combinational ID-stage read ports, with forwarding from the in-flight EX result and the pending WB entry.

Parameters:
- DW, 32, data width of registers and result bus
- AW, 5, register address width; depth = 2**AW (32)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous reset, active-high
- regcWr  input  1  EX result write enable
- regcAddr  input  AW  EX result destination register
- regcData  input  DW  EX result value
- stall  input  1  hold WB stage contents
- flush  input  1  invalidate WB stage
- re1  input  1  read port 1 enable
- raddr1  input  AW  read port 1 address
- rdata1  output  DW  read port 1 data
- re2  input  1  read port 2 enable
- raddr2  input  AW  read port 2 address
- rdata2  output  DW  read port 2 data
- wb_wr  output  1  WB stage valid write (commit strobe)
- wb_addr  output  AW  WB stage destination
- wb_data  output  DW  WB stage value

Behaviour:
- Reset: clk is one clock; reset is asynchronous and active-high on rst. While rst=1, all 32 registers, wb_wr, wb_addr and wb_data are 0 immediately, without waiting for a clock edge. rdata1/rdata2 read 0 as a consequence of the cleared state.
- WB stage update, at posedge clk, in priority order:
  - flush=1: wb_wr<=0, addr/data unchanged (flush beats stall).
  - stall=1: hold all WB registers.
  - otherwise: wb_wr<=regcWr, wb_addr<=regcAddr, wb_data<=regcData.
- Commit: at every posedge with wb_wr=1 and wb_addr!=0, reg[wb_addr]<=wb_data.
  - The commit happens in the same edge as the WB stage update; the array sees the old WB contents.
  - Repeated commits of a held (stalled) entry are idempotent.
- Latency: EX result enters WB 1 cycle after presentation and is architecturally in the array after 2 edges. It is visible on read ports from the same cycle via forwarding.
- Register 0 is never written and always reads 0.
- Read ports are purely combinational. Each port is evaluated independently with this priority:
  1. reN=0 -> rdataN=0
  2. raddrN=0 -> 0
  3. regcWr=1 and regcAddr==raddrN -> regcData (EX forward, newest)
  4. wb_wr=1 and wb_addr==raddrN -> wb_data (WB forward)
  5. else reg[raddrN]
- regcWr=1 with regcAddr=0 is legal: it is latched into WB, never committed, and never forwarded.
- Simultaneous EX and WB hits on the same address: EX value wins.
- flush does not block the current-cycle EX forward. Only the WB-stage forward is suppressed after the flushing edge.
- Reset asserted mid-operation discards any pending WB entry; no partial commit.
- No X propagation: all outputs are defined whenever rst is deasserted after reset.

Test Plan:
- Reset clears state: preload reg[5]=0xDEAD, assert rst asynchronously between edges -> rdata1 (raddr1=5, re1=1) is 0 before the next edge; wb_wr=0.
- Basic write/read: present regcWr=1, regcAddr=3, regcData=0x12345678, then idle two cycles -> wb_wr=1 one cycle after; reg[3] holds value; rdata2 (raddr2=3) = 0x12345678 with regc inputs idle.
- Forward priority: WB holds addr 7 = 0x1111 while EX presents addr 7 = 0x2222 -> rdata1 = 0x2222. Drop regcWr -> rdata1 = 0x1111 same cycle.
- Zero register: write addr 0 = 0xFFFFFFFF -> raddr1=0 reads 0 in the EX cycle, the WB cycle and afterwards; wb_wr=1 but reg[0] stays 0.
- Stall/flush: stall=1 for 3 cycles while EX changes -> wb_addr/wb_data unchanged. Assert flush and stall together -> wb_wr=0 next cycle; the flushed value is not forwarded after the edge.
- Read disable: re2=0 with raddr2 matching an EX hit -> rdata2=0.
